// File: rtl/comp_serial_ctrl.sv
// Bit-serial MSB-first magnitude compare sequencer for the 1-bit comparator cell.
// Optional COMP_EARLY_EXIT_EN: finish on the first mismatching bit.
module comp_serial_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             Amaior,
    output logic             igual,
    output logic             Amenor
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_DONE
    } state_t;

    state_t          state;
    logic [IW-1:0]   idx;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic            abit;
    logic            bbit;
    logic            diff;
    logic            last;

    // Shift instead of indexing so WIDTH=1 needs no out-of-range select
    assign a_sh = a_r >> idx;
    assign b_sh = b_r >> idx;
    assign abit = a_sh[0];
    assign bbit = b_sh[0];
    assign diff = abit ^ bbit;
    assign last = (idx == '0);

`ifndef COMP_EARLY_EXIT_EN
    logic decided;
    logic gt;
    logic dec_n;
    logic gt_n;

    assign dec_n = decided | diff;
    assign gt_n  = decided ? gt : abit;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            idx    <= '0;
            a_r    <= '0;
            b_r    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            Amaior <= 1'b0;
            igual  <= 1'b0;
            Amenor <= 1'b0;
`ifndef COMP_EARLY_EXIT_EN
            decided <= 1'b0;
            gt      <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_r   <= A;
                        b_r   <= B;
                        idx   <= IW'(WIDTH - 1);
                        busy  <= 1'b1;
                        state <= S_SCAN;
`ifndef COMP_EARLY_EXIT_EN
                        decided <= 1'b0;
                        gt      <= 1'b0;
`endif
                    end
                end
                S_SCAN: begin
`ifdef COMP_EARLY_EXIT_EN
                    if (diff) begin
                        Amaior <= abit;
                        igual  <= 1'b0;
                        Amenor <= bbit;
                        done   <= 1'b1;
                        state  <= S_DONE;
                    end else if (last) begin
                        Amaior <= 1'b0;
                        igual  <= 1'b1;
                        Amenor <= 1'b0;
                        done   <= 1'b1;
                        state  <= S_DONE;
                    end else begin
                        idx <= idx - IW'(1);
                    end
`else
                    // First mismatch wins; lower bits only advance the index
                    if (last) begin
                        Amaior <= dec_n & gt_n;
                        igual  <= ~dec_n;
                        Amenor <= dec_n & ~gt_n;
                        done   <= 1'b1;
                        state  <= S_DONE;
                    end else begin
                        decided <= dec_n;
                        gt      <= gt_n;
                        idx     <= idx - IW'(1);
                    end
`endif
                end
                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_comp_serial_ctrl.sv
// Directed bench for comp_serial_ctrl (WIDTH=4 and WIDTH=1 instances).
// Expected latencies follow COMP_EARLY_EXIT_EN when it is defined.
module tb_comp_serial_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] a;
    logic [3:0] b;
    logic       busy;
    logic       done;
    logic       amaior;
    logic       igual;
    logic       amenor;

    logic       start1;
    logic [0:0] a1;
    logic [0:0] b1;
    logic       busy1;
    logic       done1;
    logic       amaior1;
    logic       igual1;
    logic       amenor1;

    int tests;
    int fails;

`ifdef COMP_EARLY_EXIT_EN
    localparam int LAT_GT = 1;
    localparam int LAT_LT = 2;
`else
    localparam int LAT_GT = 4;
    localparam int LAT_LT = 4;
`endif

    comp_serial_ctrl #(.WIDTH(4)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .A      (a),
        .B      (b),
        .busy   (busy),
        .done   (done),
        .Amaior (amaior),
        .igual  (igual),
        .Amenor (amenor)
    );

    comp_serial_ctrl #(.WIDTH(1)) dut1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start1),
        .A      (a1),
        .B      (b1),
        .busy   (busy1),
        .done   (done1),
        .Amaior (amaior1),
        .igual  (igual1),
        .Amenor (amenor1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic run_cmp(input string tag, input logic [3:0] va, input logic [3:0] vb,
                           input int lat, input logic eg, input logic ee, input logic el);
        int n;
        @(negedge clk);
        a = va;
        b = vb;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_busy"}, busy, 1);
        chk({tag, "_done0"}, done, 0);
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            n++;
            if (done) break;
        end
        chk({tag, "_lat"}, n, lat);
        chk({tag, "_gt"}, amaior, eg);
        chk({tag, "_eq"}, igual, ee);
        chk({tag, "_lt"}, amenor, el);
        @(negedge clk);
        chk({tag, "_busy_end"}, busy, 0);
        chk({tag, "_done_end"}, done, 0);
    endtask

    initial begin
        int ndone;
        logic got_gt;
        tests = 0;
        fails = 0;
        start = 1'b0;
        start1 = 1'b0;
        a = '0;
        b = '0;
        a1 = '0;
        b1 = '0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_gt", amaior, 0);
        chk("rst_eq", igual, 0);
        chk("rst_lt", amenor, 0);
        rst_n = 1'b1;

        run_cmp("eq1010", 4'b1010, 4'b1010, 4, 0, 1, 0);
        run_cmp("gt1000", 4'b1000, 4'b0111, LAT_GT, 1, 0, 0);
        run_cmp("lt0011", 4'b0011, 4'b0101, LAT_LT, 0, 0, 1);

        // second start while busy must be ignored
        @(negedge clk);
        a = 4'b1111;
        b = 4'b0000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ndone = 0;
        got_gt = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            if (i == 2) begin
                start = 1'b1;
                a = 4'b0000;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            if (done) begin
                ndone++;
                got_gt = amaior;
            end
        end
        start = 1'b0;
        chk("ign_ndone", ndone, 1);
        chk("ign_gt", got_gt, 1);
        chk("ign_busy", busy, 0);

        // asynchronous reset mid-scan
        @(negedge clk);
        a = 4'b0101;
        b = 4'b0101;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_gt", amaior, 0);
        chk("arst_eq", igual, 0);
        chk("arst_lt", amenor, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_cmp("eq0001", 4'b0001, 4'b0001, 4, 0, 1, 0);

        // WIDTH=1 instance
        @(negedge clk);
        a1 = 1'b1;
        b1 = 1'b0;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        chk("w1_busy", busy1, 1);
        @(negedge clk);
        chk("w1_done", done1, 1);
        chk("w1_gt", amaior1, 1);
        chk("w1_eq", igual1, 0);
        @(negedge clk);
        chk("w1_done_end", done1, 0);
        chk("w1_busy_end", busy1, 0);
        a1 = 1'b0;
        b1 = 1'b0;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        @(negedge clk);
        chk("w1_done2", done1, 1);
        chk("w1_eq2", igual1, 1);
        chk("w1_gt2", amaior1, 0);
        chk("w1_lt2", amenor1, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
